// File: rtl/proto_field_lookup.sv
// Resolves a decoded protobuf field tag to its metadata slot in the current message node,
// tracking embedded-message nesting with a node-index stack.
module proto_field_lookup #(
  parameter int unsigned IDENTIFIER_SIZE      = 8,
  parameter int unsigned NUM_MSG_HIERARCHY    = 3,
  parameter int unsigned NUM_MSGS             = 3,
  parameter int unsigned MAX_FIELDS_PER_MSG   = 4,
  parameter int unsigned FIELD_META_DATA_SIZE = 20,
  parameter int unsigned ROOT_NODE            = 0
) (
  input  logic                                                       clk,
  input  logic                                                       rst_n,
  input  logic [NUM_MSGS*NUM_MSG_HIERARCHY*IDENTIFIER_SIZE-1:0]      dependencies,
  input  logic [NUM_MSGS*MAX_FIELDS_PER_MSG*FIELD_META_DATA_SIZE-1:0] node_rom,
  input  logic                                                       tag_valid,
  output logic                                                       tag_ready,
  input  logic [IDENTIFIER_SIZE-1:0]                                 tag_field_id,
  input  logic                                                       tag_pop,
  output logic                                                       meta_valid,
  input  logic                                                       meta_ready,
  output logic                                                       meta_hit,
  output logic [FIELD_META_DATA_SIZE-1:0]                            meta_data,
  output logic [$clog2(NUM_MSGS)-1:0]                                meta_node,
  output logic [$clog2(NUM_MSG_HIERARCHY)-1:0]                       meta_depth,
  output logic                                                       err_underflow,
  output logic                                                       err_overflow
);
  localparam int unsigned IW = IDENTIFIER_SIZE;
  localparam int unsigned HL = NUM_MSG_HIERARCHY;
  localparam int unsigned FW = FIELD_META_DATA_SIZE;
  localparam int unsigned NW = $clog2(NUM_MSGS);
  localparam int unsigned DW = $clog2(NUM_MSG_HIERARCHY);
  localparam int unsigned SW = $clog2(MAX_FIELDS_PER_MSG);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DESCEND} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic [NW-1:0]   node_idx_q [HL];
  logic [NW-1:0]   node_idx_d [HL];
  logic [SW-1:0]   slot_q, slot_d;
  logic [NW-1:0]   dscan_q, dscan_d;
  logic [IW-1:0]   tag_id_q, tag_id_d;
  logic            tag_ready_q, tag_ready_d;
  logic            meta_valid_q, meta_valid_d;
  logic            meta_hit_q, meta_hit_d;
  logic [FW-1:0]   meta_data_q, meta_data_d;
  logic [NW-1:0]   meta_node_q, meta_node_d;
  logic [DW-1:0]   meta_depth_q, meta_depth_d;
  logic            err_underflow_q, err_underflow_d;
  logic            err_overflow_q, err_overflow_d;

  logic [IW-1:0]   dep_arr [NUM_MSGS][HL];
  logic [FW-1:0]   rom_arr [NUM_MSGS][MAX_FIELDS_PER_MSG];
  logic [NW-1:0]   cur_node;
  logic [FW-1:0]   slot_meta;
  logic            child_match;

  for (genvar n = 0; n < NUM_MSGS; n++) begin : g_msg
    for (genvar l = 0; l < HL; l++) begin : g_lvl
      assign dep_arr[n][l] = dependencies[(n*HL+l)*IW +: IW];
    end
    for (genvar j = 0; j < MAX_FIELDS_PER_MSG; j++) begin : g_slot
      assign rom_arr[n][j] = node_rom[(n*MAX_FIELDS_PER_MSG+j)*FW +: FW];
    end
  end

  assign cur_node  = node_idx_q[depth_q];
  assign slot_meta = rom_arr[cur_node][slot_q];

  // Entry dscan_q is a direct child: same ancestry up to depth, one more level used, rest empty.
  always_comb begin
    child_match = 1'b1;
    for (int l = 0; l < HL; l++) begin
      if (l <= int'(depth_q)) begin
        if (dep_arr[dscan_q][l] != dep_arr[cur_node][l]) child_match = 1'b0;
      end else if (l == int'(depth_q) + 1) begin
        if (dep_arr[dscan_q][l] == '0) child_match = 1'b0;
      end else begin
        if (dep_arr[dscan_q][l] != '0) child_match = 1'b0;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    depth_d         = depth_q;
    node_idx_d      = node_idx_q;
    slot_d          = slot_q;
    dscan_d         = dscan_q;
    tag_id_d        = tag_id_q;
    meta_valid_d    = meta_valid_q;
    meta_hit_d      = meta_hit_q;
    meta_data_d     = meta_data_q;
    meta_node_d     = meta_node_q;
    meta_depth_d    = meta_depth_q;
    err_underflow_d = err_underflow_q;
    err_overflow_d  = err_overflow_q;

    case (state_q)
      IDLE: begin
        if (tag_valid) begin
          if (tag_pop) begin
            if (depth_q != '0) depth_d = depth_q - DW'(1);
            else               err_underflow_d = 1'b1;
          end else begin
            tag_id_d = tag_field_id;
            slot_d   = '0;
            state_d  = SCAN;
          end
        end
      end
      SCAN: begin
        if ((slot_meta[IW-1:0] != '0) && (slot_meta[IW-1:0] == tag_id_q)) begin
          meta_hit_d   = 1'b1;
          meta_data_d  = slot_meta;
          meta_node_d  = cur_node;
          meta_depth_d = depth_q;
          meta_valid_d = 1'b1;
          state_d      = EMIT;
        end else if (slot_q == SW'(MAX_FIELDS_PER_MSG - 1)) begin
          meta_hit_d   = 1'b0;
          meta_data_d  = '0;
          meta_node_d  = cur_node;
          meta_depth_d = depth_q;
          meta_valid_d = 1'b1;
          state_d      = EMIT;
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end
      EMIT: begin
        if (meta_ready) begin
          meta_valid_d = 1'b0;
          dscan_d      = '0;
          if (meta_hit_q && (meta_data_q[IW +: 2] == 2'b11)) state_d = DESCEND;
          else                                                state_d = IDLE;
        end
      end
      DESCEND: begin
        if (depth_q == DW'(HL - 1)) begin
          err_overflow_d = 1'b1;
          state_d        = IDLE;
        end else if (child_match) begin
          node_idx_d[depth_q + DW'(1)] = dscan_q;
          depth_d                      = depth_q + DW'(1);
          state_d                      = IDLE;
        end else if (dscan_q == NW'(NUM_MSGS - 1)) begin
          err_overflow_d = 1'b1;
          state_d        = IDLE;
        end else begin
          dscan_d = dscan_q + NW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    tag_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      depth_q         <= '0;
      for (int i = 0; i < HL; i++) node_idx_q[i] <= '0;
      node_idx_q[0]   <= NW'(ROOT_NODE);
      slot_q          <= '0;
      dscan_q         <= '0;
      tag_id_q        <= '0;
      tag_ready_q     <= 1'b1;
      meta_valid_q    <= 1'b0;
      meta_hit_q      <= 1'b0;
      meta_data_q     <= '0;
      meta_node_q     <= NW'(ROOT_NODE);
      meta_depth_q    <= '0;
      err_underflow_q <= 1'b0;
      err_overflow_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      depth_q         <= depth_d;
      node_idx_q      <= node_idx_d;
      slot_q          <= slot_d;
      dscan_q         <= dscan_d;
      tag_id_q        <= tag_id_d;
      tag_ready_q     <= tag_ready_d;
      meta_valid_q    <= meta_valid_d;
      meta_hit_q      <= meta_hit_d;
      meta_data_q     <= meta_data_d;
      meta_node_q     <= meta_node_d;
      meta_depth_q    <= meta_depth_d;
      err_underflow_q <= err_underflow_d;
      err_overflow_q  <= err_overflow_d;
    end
  end

  assign tag_ready     = tag_ready_q;
  assign meta_valid    = meta_valid_q;
  assign meta_hit      = meta_hit_q;
  assign meta_data     = meta_data_q;
  assign meta_node     = meta_node_q;
  assign meta_depth    = meta_depth_q;
  assign err_underflow = err_underflow_q;
  assign err_overflow  = err_overflow_q;

endmodule

// File: doc/proto_field_lookup.md
# proto_field_lookup

Resolves each decoded protobuf field tag to its field metadata by walking the message-dependency table and the per-message field ROM. It tracks message nesting with a node-index stack. It sits directly downstream of the tag/varint decoder and upstream of the struct writer, which consumes the emitted byte offset, data type and required/repeated flags.

## Interface
- IDENTIFIER_SIZE, 8, width of a message or field identifier
- NUM_MSG_HIERARCHY, 3, maximum nesting depth, i.e. levels per dependency entry
- NUM_MSGS, 3, number of message nodes
- MAX_FIELDS_PER_MSG, 4, field slots per node
- FIELD_META_DATA_SIZE, 20, metadata width: [7:0] id, [9:8] type, [17:10] offset, [18] required, [19] repeated
- ROOT_NODE, 0, node index loaded at depth 0

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- dependencies  in  NUM_MSGS*NUM_MSG_HIERARCHY*IDENTIFIER_SIZE  dependency table; entry n, level l at [(n*NUM_MSG_HIERARCHY+l)*8 +: 8]; 0 = unused level
- node_rom  in  NUM_MSGS*MAX_FIELDS_PER_MSG*FIELD_META_DATA_SIZE  field metadata; node n, slot j at [(n*MAX_FIELDS_PER_MSG+j)*20 +: 20]
- tag_valid  in  1  tag or pop request valid
- tag_ready  out  1  block idle, accepts request
- tag_field_id  in  IDENTIFIER_SIZE  field number to resolve
- tag_pop  in  1  request closes the current embedded message; no lookup is done
- meta_valid  out  1  result valid
- meta_ready  in  1  downstream accepts result
- meta_hit  out  1  field found in the current node
- meta_data  out  FIELD_META_DATA_SIZE  matched slot contents; 0 on a miss
- meta_node  out  $clog2(NUM_MSGS)  node index that was searched
- meta_depth  out  $clog2(NUM_MSG_HIERARCHY)  nesting depth at lookup
- err_underflow  out  1  sticky: pop at depth 0
- err_overflow  out  1  sticky: descent impossible (max depth or no child entry)

## Operation
- Stack: node_idx[0..NUM_MSG_HIERARCHY-1] plus a depth counter. Reset: depth=0, node_idx[0]=ROOT_NODE.
- FSM states: IDLE, SCAN, EMIT, DESCEND. tag_ready = (state==IDLE).
- IDLE, tag_valid & tag_pop:
  - If depth>0, depth decrements.
  - Else err_underflow sets.
  - State stays IDLE.
- IDLE, tag_valid & !tag_pop: latch tag_field_id, clear slot counter j, go to SCAN.
- SCAN, one slot per cycle, compares slot j id with the tag (id 0 never matches):
  - Match: latch slot, meta_hit=1, go to EMIT.
  - j==MAX_FIELDS_PER_MSG-1 with no match: meta_hit=0, meta_data=0, go to EMIT.
- EMIT: meta_valid=1. Outputs hold stable while meta_ready=0. On handshake:
  - If meta_hit and type==2'b11 (embedded message), go to DESCEND.
  - Otherwise go to IDLE.
- DESCEND scans dependency entries n=0..NUM_MSGS-1, one per cycle. With cur = dependencies[node_idx[depth]], the child test is:
  - entry[l]==cur[l] for l≤depth, and
  - entry[depth+1]!=0, and
  - entry[l]==0 for l>depth+1.
  - First match: node_idx[depth+1]=n, depth increments, go to IDLE.
  - If depth==NUM_MSG_HIERARCHY-1 (checked on the first cycle, no scan) or no entry matches, err_overflow sets, depth is unchanged, go to IDLE.
- Error flags clear only on reset.
- Reset mid-operation: any state returns to IDLE with the stack reset. Any pending result is discarded.

## Timing
- Reset values: tag_ready=1 (after the reset edge), meta_valid=0, meta_hit=0, meta_data=0, meta_node=ROOT_NODE, meta_depth=0, err_*=0.
- Lookup latency: with the tag accepted at edge T and a hit in slot i, meta_valid rises after edge T+1+i. On a miss it rises after edge T+MAX_FIELDS_PER_MSG.
- meta_valid drops the cycle after the handshake.
- A pop takes one cycle; a new request can be accepted on the next edge.
- DESCEND takes found_index+1 cycles, or NUM_MSGS cycles on a miss, before tag_ready returns high.
- Single request outstanding; there is no overlap between lookups.

## Test plan
Tables: AddressBook/Person/PhoneNumber at nodes 0/1/2 with deps {00,00,AA}/{00,BB,AA}/{CC,BB,AA}. Node0 slot0 = people (id1). Node1 slots 0..3 = phones/email/id/name. Node2 slots 0..1 = number/type.

- Reset, then tag id1 → after 1-cycle SCAN: meta_hit=1, offset 0x00, type 3, required=1, node 0, depth 0; then DESCEND → depth 1, node 1, tag_ready high 2 cycles after the handshake.
- At depth 1, tag id3 → meta_valid 2 cycles after accept (slot1): offset 0x0C, type 0, required=0. Tag id4 → offset 0x10, repeated=1, descends to node 2, depth 2.
- At depth 2, tag id2 → offset 0x18, type 1. Tag id9 → meta_hit=0, meta_data=0, meta_valid 4 cycles after accept. meta_ready held low 5 cycles → outputs unchanged.
- Pop ×2 → depth 0. A third pop → err_underflow=1, depth stays 0.
- Modified ROM with an embedded-type field in node 2 at depth 2 → meta_hit=1, then err_overflow=1, depth stays 2.
- rst_n low for one cycle during SCAN → next cycle: IDLE, depth 0, meta_valid=0, errors 0. No stale result is emitted.
